muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Iterative multiply/divide sequencer for the RV32M extension, sitting beside the ALU in the execute stage. When a MUL/DIV-class instruction reaches execute, it captures the operands and runs a 32-step shift-add multiply or restoring divide. While it runs, it holds F/D/E stalled through the hazard logic. It returns the 32-bit result in a single done cycle, and execute forwards that result into the E/M register in place of ALUResultE.

## Interface
- XLEN, 32, operand/result width (only 32 supported)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- StartE  input  1  valid M-extension op in execute
- MulDivOpE  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcAE  input  XLEN  rs1 value (post-forwarding)
- SrcBE  input  XLEN  rs2 value (post-forwarding)
- RdE  input  5  destination register
- FlushE  input  1  execute-stage flush (branch/jump redirect)
- StallMD  output  1  stall request to hazard unit for F/D/E
- MDDoneE  output  1  result valid this cycle
- MDResultE  output  XLEN  result
- MDRdE  output  5  destination of the completed op

## Operation
- States:
  - IDLE: no op in flight.
  - RUN: one iteration per cycle, 5-bit counter 0..31.
  - FIX: sign correction and special-case override.
  - DONE: result presented.
- IDLE → RUN on StartE=1 and FlushE=0. Op, RdE, operand magnitudes, and sign flags are captured on that edge. Later changes on SrcAE/SrcBE are ignored.
- RUN → FIX when the counter reaches 31. FIX → DONE. DONE → IDLE unconditionally.
- Multiply:
  - Unsigned 32x32 shift-add on magnitudes into a 64-bit accumulator.
  - Signedness: MUL/MULH treat both operands as signed; MULHSU treats A as signed and B as unsigned; MULHU treats both as unsigned.
  - FIX negates the 64-bit product if the operand signs differ.
  - MUL returns bits [31:0]; MULH* return bits [63:32].
- Divide:
  - Restoring divide on magnitudes: one quotient bit per cycle, 33-bit trial subtract.
  - FIX negates the quotient if signs differ (DIV only) and negates the remainder if the dividend is negative (REM only).
- Special cases, applied in FIX in all configurations:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = original dividend.
  - DIV/REM overflow, 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- FlushE=1 in RUN or FIX: next state IDLE, op discarded, no MDDoneE.
- FlushE=1 in DONE: MDDoneE suppressed; state still returns to IDLE.
- StartE is ignored outside IDLE; there is no queuing.
- rst mid-operation: IDLE next edge; all outputs return to reset values.

## Timing
- Reset values: StallMD=0, MDDoneE=0, MDResultE=0, MDRdE=0, state IDLE, counter 0.
- StallMD is combinational: (IDLE & StartE & ~FlushE) | RUN | FIX. It is 0 in DONE, so the pipeline advances and captures the result that cycle.
- MDDoneE = DONE & ~FlushE. MDResultE and MDRdE are registered and stable throughout DONE.
- Full-path latency: accept in cycle T0, RUN in T1–T32, FIX in T33, DONE in T34. StallMD is high for 34 cycles (T0–T33).
- Back-to-back ops: the earliest next accept is T35, when the next instruction reaches E.

## Configuration
- MULDIV_FAST_PATH_EN defined: at accept, the following go IDLE → DONE directly, with the result ready in T1 and StallMD high only in T0:
  - divide by zero
  - DIV/REM overflow
  - any multiply with a zero operand
- Undefined: every op takes the full 34-cycle path. Results are identical in both builds.

## Test plan
- MUL, A=7, B=0xFFFFFFFD (−3) → MDResultE=0xFFFFFFEB in T34; StallMD high T0–T33; MDRdE matches RdE.
- MULHU, 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH, same operands → 0x00000000. MULHSU, A=0xFFFFFFFF, B=2 → 0xFFFFFFFF.
- DIV, −7/2 → 0xFFFFFFFD. REM, −7/2 → 0xFFFFFFFF. DIVU, 100/7 → 14. REMU, 100/7 → 2.
- DIV, 5/0 → 0xFFFFFFFF. REM, 5/0 → 5. DIV, 0x80000000/0xFFFFFFFF → 0x80000000. Check done in T34 without the macro and in T1 with MULDIV_FAST_PATH_EN.
- FlushE pulsed in T10 of a DIV → IDLE in T11, MDDoneE never asserts. A new StartE in T12 is accepted and completes correctly in T46.
- rst asserted in T20 of a MUL → all outputs 0 next cycle. StartE held during reset is not accepted until rst deasserts.

Source files
------------

// File: rtl/muldiv_if.sv
// Execute-stage handshake between the pipeline and the iterative multiply/divide sequencer.
interface muldiv_if #(parameter int XLEN = 32);
    logic            StartE;
    logic [2:0]      MulDivOpE;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic [4:0]      RdE;
    logic            FlushE;
    logic            StallMD;
    logic            MDDoneE;
    logic [XLEN-1:0] MDResultE;
    logic [4:0]      MDRdE;

    modport master (
        output StartE, MulDivOpE, SrcAE, SrcBE, RdE, FlushE,
        input  StallMD, MDDoneE, MDResultE, MDRdE
    );

    modport slave (
        input  StartE, MulDivOpE, SrcAE, SrcBE, RdE, FlushE,
        output StallMD, MDDoneE, MDResultE, MDRdE
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// RV32M iterative sequencer: 32-step shift-add multiply / restoring divide on magnitudes.
// Optional MULDIV_FAST_PATH_EN: trivial ops (x/0, signed overflow, multiply by zero) skip to DONE.
//
// state | meaning
// IDLE  | no op in flight
// RUN   | one iteration per cycle, cnt 0..31
// FIX   | sign correction and special-case override
// DONE  | result presented
module muldiv_ctrl (
    input logic   clk,
    input logic   rst,
    muldiv_if.slave md
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [2:0]  op_q;
    logic        neg_a, neg_b, div0_q, ovf_q;
    logic [31:0] a_orig, opnd;
    logic [63:0] prod;

    logic        op_div, signed_a, signed_b, neg_a_in, neg_b_in, accept, ovf_in;
    logic [31:0] mag_a_in, mag_b_in;

    assign op_div   = md.MulDivOpE[2];
    assign signed_a = op_div ? ~md.MulDivOpE[0] : (md.MulDivOpE[1:0] != 2'b11);
    assign signed_b = op_div ? ~md.MulDivOpE[0] : ~md.MulDivOpE[1];
    assign neg_a_in = signed_a & md.SrcAE[31];
    assign neg_b_in = signed_b & md.SrcBE[31];
    assign mag_a_in = neg_a_in ? -md.SrcAE : md.SrcAE;
    assign mag_b_in = neg_b_in ? -md.SrcBE : md.SrcBE;
    assign ovf_in   = op_div & ~md.MulDivOpE[0] & (md.SrcAE == 32'h8000_0000)
                      & (md.SrcBE == 32'hFFFF_FFFF);
    assign accept   = (state == IDLE) & md.StartE & ~md.FlushE;

    function automatic logic [31:0] special_result(input logic [2:0] op,
                                                   input logic [31:0] a,
                                                   input logic zero_b);
        if (zero_b) special_result = op[1] ? a : 32'hFFFF_FFFF;
        else        special_result = op[1] ? 32'h0 : 32'h8000_0000;
    endfunction

    logic [32:0] sum, shifted, trial;
    logic [63:0] mul_next, div_next, mul_fix;
    logic [31:0] q_fix, r_fix, fix_res;

    always_comb begin
        sum      = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, opnd} : 33'd0);
        mul_next = {sum, prod[31:1]};
        // Partial remainder stays below the divisor, so dropping bit 32 after a good subtract is safe.
        shifted  = {prod[63:32], prod[31]};
        trial    = shifted - {1'b0, opnd};
        div_next = trial[32] ? {shifted[31:0], prod[30:0], 1'b0}
                             : {trial[31:0],   prod[30:0], 1'b1};
        mul_fix  = (neg_a ^ neg_b) ? -prod : prod;
        q_fix    = (neg_a ^ neg_b) ? -prod[31:0] : prod[31:0];
        r_fix    = neg_a ? -prod[63:32] : prod[63:32];
        if (div0_q | ovf_q)
            fix_res = special_result(op_q, a_orig, div0_q);
        else if (op_q[2])
            fix_res = op_q[1] ? r_fix : q_fix;
        else
            fix_res = (op_q[1:0] == 2'b00) ? mul_fix[31:0] : mul_fix[63:32];
    end

`ifdef MULDIV_FAST_PATH_EN
    logic        fast_in;
    logic [31:0] fast_res;
    assign fast_in  = op_div ? ((md.SrcBE == 32'h0) | ovf_in)
                             : ((md.SrcAE == 32'h0) | (md.SrcBE == 32'h0));
    assign fast_res = op_div ? special_result(md.MulDivOpE, md.SrcAE, md.SrcBE == 32'h0) : 32'h0;
`endif

    assign md.StallMD = ~rst & (accept | (state == RUN) | (state == FIX));
    assign md.MDDoneE = (state == DONE) & ~md.FlushE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            op_q         <= '0;
            neg_a        <= 1'b0;
            neg_b        <= 1'b0;
            div0_q       <= 1'b0;
            ovf_q        <= 1'b0;
            a_orig       <= '0;
            opnd         <= '0;
            prod         <= '0;
            md.MDResultE <= '0;
            md.MDRdE     <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state    <= RUN;
                    cnt      <= '0;
                    op_q     <= md.MulDivOpE;
                    md.MDRdE <= md.RdE;
                    neg_a    <= neg_a_in;
                    neg_b    <= neg_b_in;
                    a_orig   <= md.SrcAE;
                    div0_q   <= op_div & (md.SrcBE == 32'h0);
                    ovf_q    <= ovf_in;
                    opnd     <= op_div ? mag_b_in : mag_a_in;
                    prod     <= {32'h0, op_div ? mag_a_in : mag_b_in};
`ifdef MULDIV_FAST_PATH_EN
                    if (fast_in) begin
                        state        <= DONE;
                        md.MDResultE <= fast_res;
                    end
`endif
                end
                RUN: begin
                    prod <= op_q[2] ? div_next : mul_next;
                    cnt  <= cnt + 5'd1;
                    if (md.FlushE)
                        state <= IDLE;
                    else if (cnt == 5'd31)
                        state <= FIX;
                end
                FIX: begin
                    cnt <= '0;
                    if (md.FlushE) begin
                        state <= IDLE;
                    end else begin
                        state        <= DONE;
                        md.MDResultE <= fix_res;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: driver pushes expected results, negedge monitor pops on MDDoneE.
module tb_muldiv_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_if bus();
    muldiv_ctrl dut (.clk(clk), .rst(rst), .md(bus));

`ifdef MULDIV_FAST_PATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          cycle;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (bus.MDDoneE) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(bus.MDResultE), 64'hDEAD_DEAD_DEAD_DEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", 64'(bus.MDResultE), 64'(e.res));
                chk("rd", 64'(bus.MDRdE), 64'(e.rd));
                chk("done_cycle", 64'(cyc), 64'(e.cycle));
            end
        end
    end

    // Issues one op, scrambles inputs after accept, and measures the stall window.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] res, input bit fast,
                          input bit release_rst);
        int lat, stalls;
        bit seen;
        lat = (FAST && fast) ? 1 : 34;
        @(posedge clk); #1;
        if (release_rst) rst = 1'b0;
        bus.StartE = 1'b1; bus.MulDivOpE = op; bus.SrcAE = a; bus.SrcBE = b; bus.RdE = rd;
        sb.push_back('{res, rd, cyc + lat});
        @(negedge clk);
        chk("stall_t0", 64'(bus.StallMD), 64'd1);
        stalls = 1;
        @(posedge clk); #1;
        bus.StartE = 1'b0; bus.SrcAE = ~a; bus.SrcBE = b ^ 32'h5A5A_A5A5; bus.RdE = ~rd;
        seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (bus.MDDoneE) begin
                seen = 1'b1;
                chk("stall_in_done", 64'(bus.StallMD), 64'd0);
            end else if (bus.StallMD) begin
                stalls++;
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("stall_cycles", 64'(stalls), 64'(lat));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst = 1'b1;
        bus.StartE = 1'b0; bus.MulDivOpE = '0; bus.SrcAE = '0; bus.SrcBE = '0;
        bus.RdE = '0; bus.FlushE = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 64'(bus.StallMD), 64'd0);
        chk("rst_done", 64'(bus.MDDoneE), 64'd0);
        chk("rst_result", 64'(bus.MDResultE), 64'd0);
        chk("rst_rd", 64'(bus.MDRdE), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(3'b000, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 1'b0, 1'b0);
        run_op(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op(3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'h0000_0000, 1'b0, 1'b0);
        run_op(3'b010, 32'hFFFF_FFFF,  32'd2,         5'd4,  32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(3'b000, 32'h8000_0000,  32'hFFFF_FFFF, 5'd5,  32'h8000_0000, 1'b0, 1'b0);
        run_op(3'b001, 32'h8000_0000,  32'hFFFF_FFFF, 5'd6,  32'h0000_0000, 1'b0, 1'b0);
        run_op(3'b100, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op(3'b110, 32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(3'b101, 32'd100,        32'd7,         5'd9,  32'd14,        1'b0, 1'b0);
        run_op(3'b111, 32'd100,        32'd7,         5'd10, 32'd2,         1'b0, 1'b0);
        run_op(3'b101, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h0000_0000, 1'b0, 1'b0);
        run_op(3'b111, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1'b0, 1'b0);
        run_op(3'b100, 32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op(3'b110, 32'd5,          32'd0,         5'd14, 32'd5,         1'b1, 1'b0);
        run_op(3'b100, 32'hFFFF_FFF9,  32'd0,         5'd15, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op(3'b110, 32'hFFFF_FFF9,  32'd0,         5'd16, 32'hFFFF_FFF9, 1'b1, 1'b0);
        run_op(3'b101, 32'd5,          32'd0,         5'd17, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op(3'b111, 32'hFFFF_FFF0,  32'd0,         5'd18, 32'hFFFF_FFF0, 1'b1, 1'b0);
        run_op(3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 1'b1, 1'b0);
        run_op(3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd20, 32'h0000_0000, 1'b1, 1'b0);
        run_op(3'b000, 32'h0000_1234,  32'd0,         5'd21, 32'h0000_0000, 1'b1, 1'b0);
        run_op(3'b011, 32'd0,          32'hFFFF_FFFF, 5'd22, 32'h0000_0000, 1'b1, 1'b0);

        // Flush a DIV in T10; a fresh op in T12 must complete in T46.
        @(posedge clk); #1;
        bus.StartE = 1'b1; bus.MulDivOpE = 3'b100; bus.SrcAE = 32'd1000; bus.SrcBE = 32'd3;
        bus.RdE = 5'd23;
        t0 = cyc;
        @(posedge clk); #1;
        bus.StartE = 1'b0;
        while (cyc < t0 + 10) begin
            @(posedge clk); #1;
        end
        bus.FlushE = 1'b1;
        @(posedge clk); #1;
        bus.FlushE = 1'b0;
        @(negedge clk);
        chk("flush_idle_stall", 64'(bus.StallMD), 64'd0);
        run_op(3'b101, 32'd100, 32'd7, 5'd24, 32'd14, 1'b0, 1'b0);

        // Reset in T20 of a MUL, with StartE held through reset.
        @(posedge clk); #1;
        bus.StartE = 1'b1; bus.MulDivOpE = 3'b000; bus.SrcAE = 32'd3; bus.SrcBE = 32'd5;
        bus.RdE = 5'd25;
        t0 = cyc;
        @(posedge clk); #1;
        bus.StartE = 1'b0;
        while (cyc < t0 + 20) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        bus.StartE = 1'b1; bus.MulDivOpE = 3'b000; bus.SrcAE = 32'd6; bus.SrcBE = 32'd7;
        bus.RdE = 5'd26;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_stall", 64'(bus.StallMD), 64'd0);
        chk("midrst_done", 64'(bus.MDDoneE), 64'd0);
        chk("midrst_result", 64'(bus.MDResultE), 64'd0);
        chk("midrst_rd", 64'(bus.MDRdE), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_stall", 64'(bus.StallMD), 64'd0);
        run_op(3'b000, 32'd6, 32'd7, 5'd26, 32'd42, 1'b0, 1'b1);

        repeat (5) @(posedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
